usart_hash_rx: RTL and testbench

- Serial receiver that loads a 128-bit MD5 target digest into the cracker over the same 8N1 UART link the result transmitter drives, on the host-to-board direction.
- Receives 16 raw bytes, assembles them into a big-endian [0:127] digest and presents it atomically with a one-cycle valid strobe.
- Sits between the board RX pin and the generator's hash comparator; replaces the hard-coded target constant.

---
 rtl/usart_hash_rx_pkg.sv | 28 ++
 rtl/usart_hash_rx_if.sv | 30 +++
 rtl/usart_hash_rx_core.sv | 147 ++++++++++++++
 rtl/usart_hash_rx.sv | 107 ++++++++++
 tb/tb_usart_hash_rx.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/usart_hash_rx_pkg.sv
// Shared definitions for the MD5 target-digest UART receiver.
//   - baud divider derivation (DIV = clock / baud, HALF = DIV / 2)
//   - receiver FSM state encoding
//   - digest width and the big-endian digest type ([0:127], byte k at [8k:8k+7])
package usart_hash_rx_pkg;

  localparam int DIGEST_W = 128;

  typedef logic [0:DIGEST_W-1] digest_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  // Clock cycles per bit, truncated; must come out >= 4 for the mid-bit
  // sampling scheme to have room for the synchroniser latency.
  function automatic int calc_div(input int clk_hz, input int baud_rate);
    return clk_hz / baud_rate;
  endfunction

  function automatic int calc_half(input int div);
    return div / 2;
  endfunction

endpackage

// File: rtl/usart_hash_rx_if.sv
// Bundle of the receiver's line input and result outputs.
//   rx          : UART line, idle high (driven by the host side)
//   rx_led      : high while a character is in flight
//   byte_out    : last correctly framed byte
//   byte_strobe : one-cycle pulse when byte_out updates
//   frame_err   : one-cycle pulse on false start or bad stop bit
//   hash        : last complete digest, byte k at bits [8k:8k+7]
//   hash_valid  : one-cycle pulse when hash updates
// master = host / consumer side, slave = receiver side.
interface usart_hash_rx_if import usart_hash_rx_pkg::*; ();

  logic       rx;
  logic       rx_led;
  logic [7:0] byte_out;
  logic       byte_strobe;
  logic       frame_err;
  digest_t    hash;
  logic       hash_valid;

  modport master (
    output rx,
    input  rx_led, byte_out, byte_strobe, frame_err, hash, hash_valid
  );

  modport slave (
    input  rx,
    output rx_led, byte_out, byte_strobe, frame_err, hash, hash_valid
  );

endinterface

// File: rtl/usart_hash_rx_core.sv
// 8N1 UART byte receiver.
//   clk, reset  : system clock, synchronous active-low reset
//   rx          : raw asynchronous line input
//   rx_led      : high in START, DATA and STOP
//   byte_out    : last byte received with a good stop bit
//   byte_strobe : one-cycle pulse when byte_out updates
//   frame_err   : one-cycle pulse on false start or bad stop bit
//   stop_err    : one-cycle pulse on bad stop bit only (drops the frame)
module usart_rx_core import usart_hash_rx_pkg::*; #(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_led,
  output logic [7:0] byte_out,
  output logic       byte_strobe,
  output logic       frame_err,
  output logic       stop_err
);

  localparam int HALF  = calc_half(DIV);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);

  rx_state_e        state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_strobe_q, byte_strobe_d;
  logic             frame_err_q, frame_err_d;
  logic             stop_err_q, stop_err_d;

  // State register. The synchroniser and edge history preset to 1 so a
  // line that is low coming out of reset is not mistaken for a start edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      prev_q        <= 1'b1;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      byte_out_q    <= '0;
      byte_strobe_q <= 1'b0;
      frame_err_q   <= 1'b0;
      stop_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      byte_out_q    <= byte_out_d;
      byte_strobe_q <= byte_strobe_d;
      frame_err_q   <= frame_err_d;
      stop_err_q    <= stop_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d       = state_q;
    sync1_d       = rx;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    byte_out_d    = byte_out_q;
    byte_strobe_d = 1'b0;
    frame_err_d   = 1'b0;
    stop_err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Edge detection rather than level: after a break (line held low)
        // the line must go high again before a new start is accepted.
        if (prev_q && !sync2_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!sync2_q) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            frame_err_d = 1'b1;    // line went back high: glitch, not a start bit
            state_d     = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d     = '0;
          shift_d   = {sync2_q, shift_q[7:1]};   // LSB arrives first
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (sync2_q) begin
            byte_out_d    = shift_q;
            byte_strobe_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            stop_err_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    rx_led = (state_q != ST_IDLE);
  end

  assign byte_out    = byte_out_q;
  assign byte_strobe = byte_strobe_q;
  assign frame_err   = frame_err_q;
  assign stop_err    = stop_err_q;

endmodule

// File: rtl/usart_hash_rx.sv
// MD5 target-digest receiver: collects n_bytes UART bytes into a shadow
// buffer and publishes them atomically as the comparator's target hash.
//   clk, reset : system clock, synchronous active-low reset
//   bus        : slave side of usart_hash_rx_if (rx in; byte/hash results out)
// A partial frame is discarded on a bad stop bit or after timeout_bits idle
// bit periods; hash only ever changes to a complete digest.
module usart_hash_rx import usart_hash_rx_pkg::*; #(
  parameter int fsm_clk_freq = 16000000,
  parameter int baud         = 115200,
  parameter int n_bytes      = 16,
  parameter int timeout_bits = 20
) (
  input  logic            clk,
  input  logic            reset,
  usart_hash_rx_if.slave  bus
);

  localparam int DIV    = calc_div(fsm_clk_freq, baud);
  localparam int CNT_W  = $clog2(n_bytes);
  localparam int TO_CYC = timeout_bits * DIV;
  localparam int TO_W   = $clog2(TO_CYC);
  localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(n_bytes - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_CYC - 1);

  logic       rx_led;
  logic [7:0] byte_out;
  logic       byte_strobe;
  logic       frame_err;
  logic       stop_err;

  usart_rx_core #(.DIV(DIV)) u_core (
    .clk         (clk),
    .reset       (reset),
    .rx          (bus.rx),
    .rx_led      (rx_led),
    .byte_out    (byte_out),
    .byte_strobe (byte_strobe),
    .frame_err   (frame_err),
    .stop_err    (stop_err)
  );

  logic [CNT_W-1:0] count_q, count_d;
  logic [TO_W-1:0]  idle_cnt_q, idle_cnt_d;
  digest_t          shadow_q, shadow_d;
  digest_t          hash_q, hash_d;
  logic             hash_valid_q, hash_valid_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q      <= '0;
      idle_cnt_q   <= '0;
      // NOTE: the data registers are reset too: hash must read 0 after reset.
      shadow_q     <= '0;
      hash_q       <= '0;
      hash_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      idle_cnt_q   <= idle_cnt_d;
      shadow_q     <= shadow_d;
      hash_q       <= hash_d;
      hash_valid_q <= hash_valid_d;
    end
  end

  always_comb begin
    count_d      = count_q;
    idle_cnt_d   = idle_cnt_q;
    shadow_d     = shadow_q;
    hash_d       = hash_q;
    hash_valid_d = 1'b0;

    // Idle timeout only runs with a partial frame pending and the line idle;
    // any character in flight (which starts with a start edge) clears it.
    if (count_q != '0 && !rx_led) begin
      if (idle_cnt_q == TO_LAST) begin
        idle_cnt_d = '0;
        count_d    = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end else begin
      idle_cnt_d = '0;
    end

    if (stop_err) count_d = '0;

    // Byte arrival is last so that frame completion wins over everything else.
    if (byte_strobe) begin
      shadow_d[8*int'(count_q) +: 8] = byte_out;
      if (count_q == N_LAST) begin
        hash_d       = shadow_d;
        hash_valid_d = 1'b1;
        count_d      = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  assign bus.rx_led      = rx_led;
  assign bus.byte_out    = byte_out;
  assign bus.byte_strobe = byte_strobe;
  assign bus.frame_err   = frame_err;
  assign bus.hash        = hash_q;
  assign bus.hash_valid  = hash_valid_q;

endmodule

// File: tb/tb_usart_hash_rx.sv
// Self-checking bench for usart_hash_rx at DIV = 16. A bit-level UART
// driver feeds the line; a byte-level model tracks expected bytes, the
// pending partial frame and the expected digest.
module tb_usart_hash_rx;

  localparam int CLK_HZ  = 1600000;
  localparam int BAUD    = 100000;
  localparam int DIV     = 16;
  localparam int NB      = 16;
  localparam int TO_BITS = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  usart_hash_rx_if bus_if ();

  usart_hash_rx #(
    .fsm_clk_freq (CLK_HZ),
    .baud         (BAUD),
    .n_bytes      (NB),
    .timeout_bits (TO_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- output monitor (sampled on falling edge) ----------------
  int         strobe_cnt   = 0;
  int         ferr_cnt     = 0;
  int         hv_cnt       = 0;
  int         led_cycles   = 0;
  int         hv_misalign  = 0;
  int         hv_at_strobe = 0;
  logic       prev_strobe  = 1'b0;
  logic [7:0] got_bytes[$];

  always @(negedge clk) begin
    if (bus_if.byte_strobe) begin
      strobe_cnt++;
      got_bytes.push_back(bus_if.byte_out);
    end
    if (bus_if.frame_err) ferr_cnt++;
    if (bus_if.rx_led) led_cycles++;
    if (bus_if.hash_valid) begin
      hv_cnt++;
      hv_at_strobe = strobe_cnt;
      if (!prev_strobe) hv_misalign++;
    end
    prev_strobe = bus_if.byte_strobe;
  end

  // ---------------- reference model ----------------
  logic [7:0]   exp_bytes[$];
  logic [7:0]   partial[$];
  logic [127:0] model_hash = '0;
  int           exp_hv     = 0;

  task automatic bit_period(input logic v);
    bus_if.rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus_if.rx = 1'b1;
    repeat (n) @(negedge clk);
    if (n >= TO_BITS * DIV) partial.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(b[i]);
    bit_period(good_stop);
    bus_if.rx = 1'b1;
    if (good_stop) begin
      exp_bytes.push_back(b);
      partial.push_back(b);
      if (partial.size() == NB) begin
        model_hash = '0;
        foreach (partial[k]) model_hash = (model_hash << 8) | 128'(partial[k]);
        partial.delete();
        exp_hv++;
      end
    end else begin
      partial.delete();
    end
  endtask

  task automatic send_random_frame(input int max_gap);
    for (int i = 0; i < NB; i++) begin
      send_byte(8'($urandom), 1'b1);
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int s0, f0, h0, l0;
  logic [127:0] held_hash;
  logic [127:0] vec_a = 128'haef656fe0f5a36d58ae1029630ba25e2;

  initial begin
    bus_if.rx = 1'b1;
    reset     = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_rx_led",      128'(bus_if.rx_led),      128'd0);
    check("reset_byte_out",    128'(bus_if.byte_out),    128'd0);
    check("reset_byte_strobe", 128'(bus_if.byte_strobe), 128'd0);
    check("reset_frame_err",   128'(bus_if.frame_err),   128'd0);
    check("reset_hash",        bus_if.hash,              128'd0);
    check("reset_hash_valid",  128'(bus_if.hash_valid),  128'd0);
    reset = 1'b1;
    idle(10);

    // Single byte.
    s0 = strobe_cnt; f0 = ferr_cnt; h0 = hv_cnt; l0 = led_cycles;
    send_byte(8'hA5, 1'b1);
    idle(8);
    check("single_strobes",  128'(strobe_cnt - s0), 128'd1);
    check("single_byte_out", 128'(bus_if.byte_out), 128'hA5);
    check("single_ferr",     128'(ferr_cnt - f0),   128'd0);
    check("single_hv",       128'(hv_cnt - h0),     128'd0);
    check("single_led_len",  128'((led_cycles - l0 >= 9*DIV) && (led_cycles - l0 <= 10*DIV)), 128'd1);

    // Timeout drops the lone byte, then a known digest back-to-back.
    idle(21 * DIV);
    h0 = hv_cnt;
    for (int k = 0; k < NB; k++) send_byte(vec_a[127 - 8*k -: 8], 1'b1);
    idle(8);
    check("vec_a_hash",       bus_if.hash,            vec_a);
    check("vec_a_model",      bus_if.hash,            model_hash);
    check("vec_a_hv",         128'(hv_cnt - h0),      128'd1);
    check("vec_a_hv_aligned", 128'(hv_at_strobe),     128'(strobe_cnt));

    // Short low glitch on an idle line.
    s0 = strobe_cnt; f0 = ferr_cnt;
    bus_if.rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(2 * DIV);
    check("glitch_ferr",    128'(ferr_cnt - f0),    128'd1);
    check("glitch_strobes", 128'(strobe_cnt - s0),  128'd0);
    check("glitch_led",     128'(bus_if.rx_led),    128'd0);

    // Bad stop bit mid-frame discards the partial frame.
    held_hash = model_hash;
    f0 = ferr_cnt; h0 = hv_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
    s0 = strobe_cnt;
    send_byte(8'h3C, 1'b0);
    idle(2 * DIV);
    check("badstop_ferr",    128'(ferr_cnt - f0),   128'd1);
    check("badstop_strobe",  128'(strobe_cnt - s0), 128'd0);
    check("badstop_hash",    bus_if.hash,           held_hash);
    check("badstop_hv",      128'(hv_cnt - h0),     128'd0);
    for (int i = 0; i < NB; i++) send_byte(8'(i), 1'b1);
    idle(8);
    check("seq_hash",  bus_if.hash, 128'h000102030405060708090a0b0c0d0e0f);
    check("seq_model", bus_if.hash, model_hash);
    check("seq_hv",    128'(hv_cnt - h0), 128'd1);

    // Idle timeout between frames.
    h0 = hv_cnt;
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b1);
    idle(21 * DIV);
    check("timeout_hash_held", bus_if.hash, model_hash);
    for (int i = 0; i < NB; i++) send_byte(8'hFF, 1'b1);
    idle(8);
    check("timeout_hash", bus_if.hash,        {128{1'b1}});
    check("timeout_hv",   128'(hv_cnt - h0),  128'd1);

    // Random frames with random short gaps.
    for (int f = 0; f < 3; f++) begin
      h0 = hv_cnt;
      send_random_frame(DIV);
      idle(8);
      check($sformatf("rand%0d_hash", f), bus_if.hash,       model_hash);
      check($sformatf("rand%0d_hv", f),   128'(hv_cnt - h0), 128'd1);
    end

    // Reset during bit 4 of byte 10.
    for (int i = 0; i < 9; i++) send_byte(8'($urandom), 1'b1);
    begin
      logic [7:0] b;
      b = 8'($urandom);
      bit_period(1'b0);
      for (int i = 0; i < 4; i++) bit_period(b[i]);
      bus_if.rx = b[4];
      repeat (DIV / 2) @(negedge clk);
    end
    reset = 1'b0;
    bus_if.rx = 1'b1;
    repeat (2) @(negedge clk);
    partial.delete();
    model_hash = '0;
    check("midrst_rx_led",     128'(bus_if.rx_led),      128'd0);
    check("midrst_byte_out",   128'(bus_if.byte_out),    128'd0);
    check("midrst_strobe",     128'(bus_if.byte_strobe), 128'd0);
    check("midrst_frame_err",  128'(bus_if.frame_err),   128'd0);
    check("midrst_hash",       bus_if.hash,              128'd0);
    check("midrst_hash_valid", 128'(bus_if.hash_valid),  128'd0);
    reset = 1'b1;
    idle(2 * DIV);
    h0 = hv_cnt;
    send_random_frame(0);
    idle(8);
    check("postrst_hash", bus_if.hash,       model_hash);
    check("postrst_hv",   128'(hv_cnt - h0), 128'd1);

    // Whole-run byte stream and strobe/hash_valid bookkeeping.
    check("byte_count", 128'(got_bytes.size()), 128'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
      if (got_bytes[i] !== exp_bytes[i])
        check($sformatf("byte_%0d", i), 128'(got_bytes[i]), 128'(exp_bytes[i]));
    check("byte_stream_len_nonzero", 128'(got_bytes.size() > 100), 128'd1);
    check("hv_total",    128'(hv_cnt),      128'(exp_hv));
    check("hv_misalign", 128'(hv_misalign), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
